// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;

    localparam int unsigned DefaultWidth = 4;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - br, with borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic br,
    output logic d,
    output logic br_next
);

    assign d       = x ^ y ^ br;
    assign br_next = (~x & y) | (~(x ^ y) & br);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int unsigned   CntW    = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              br_q, br_d;
    logic              bout_q, bout_d;
    logic              d_bit;
    logic              br_next;

    full_subtractor u_full_subtractor (
        .x       (a_q[0]),
        .y       (b_q[0]),
        .br      (br_q),
        .d       (d_bit),
        .br_next (br_next)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        br_d    = br_q;
        diff_d  = diff_q;
        bout_d  = bout_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = br_next;
                acc_d = {d_bit, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + CntW'(1);
                // Outputs change only on the final bit so they hold steady during the shift.
                if (cnt_q == LastCnt) begin
                    diff_d  = {d_bit, acc_q[WIDTH-1:1]};
                    bout_d  = br_next;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            br_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            br_q    <= br_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign ready = (state_q == StIdle);
    assign done  = (state_q == StDone);
    assign diff  = diff_q;
    assign bout  = bout_q;

endmodule
